codec_init_seq: RTL and testbench

CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

---
 rtl/codec_init_seq.sv | 187 ++++++++++++++++++
 tb/tb_codec_init_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_seq.sv
// codec_init_seq: walks an external register table and issues 2-byte I2C writes.
// Optional CODEC_INIT_RETRY_EN: NACKed entries are retried up to 3 times.
module codec_init_seq #(
  parameter int         NUM_REGS     = 10,
  parameter int         IDX_W        = 4,
  parameter logic [6:0] PERIPH_ADDR  = 7'b0011010,
  parameter int         PAUSE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_data,
  output logic             i2c_enable,
  output logic             i2c_mode,
  output logic [6:0]       i2c_addr,
  output logic [7:0]       i2c_byte,
  input  logic             i2c_ready,
  input  logic             i2c_wip,
  input  logic             i2c_ack_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       state_info
);

  localparam int CNT_W =
    (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_SEND_HI   = 4'd2,
    S_SEND_LO   = 4'd3,
    S_WAIT_IDLE = 4'd4,
    S_PAUSE     = 4'd5,
    S_NEXT      = 4'd6,
    S_DONE      = 4'd14,
    S_ERR       = 4'd15
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      entry_q, entry_d;
  logic             wip_q;
  logic             wip_rise;
  logic             ack_win;

`ifdef CODEC_INIT_RETRY_EN
  logic [1:0] retry_q, retry_d;
  logic       pend_q, pend_d;
`endif

  assign wip_rise = i2c_wip & ~wip_q;
  assign ack_win  = (state_q == S_SEND_HI) |
                    (state_q == S_SEND_LO) |
                    (state_q == S_WAIT_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
`ifdef CODEC_INIT_RETRY_EN
    retry_d = retry_q;
    pend_d  = pend_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
`ifdef CODEC_INIT_RETRY_EN
          retry_d = '0;
          pend_d  = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        entry_d = tbl_data;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (wip_rise) state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (wip_rise) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (i2c_ready) begin
          state_d = S_PAUSE;
          cnt_d   = CNT_LOAD;
        end
      end
      S_PAUSE: begin
        if (cnt_q == '0) begin
          state_d = S_NEXT;
`ifdef CODEC_INIT_RETRY_EN
          if (pend_q) begin
            state_d = S_LOAD;
            pend_d  = 1'b0;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_LOAD;
`ifdef CODEC_INIT_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a NACK overrides any wip edge or ready seen in the same cycle
    if (ack_win && i2c_ack_err) begin
`ifdef CODEC_INIT_RETRY_EN
      if (retry_q == 2'd3) begin
        state_d = S_ERR;
      end else begin
        retry_d = retry_q + 2'd1;
        pend_d  = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = S_PAUSE;
      end
`else
      state_d = S_ERR;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      entry_q <= '0;
      wip_q   <= 1'b0;
`ifdef CODEC_INIT_RETRY_EN
      retry_q <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      wip_q   <= i2c_wip;
`ifdef CODEC_INIT_RETRY_EN
      retry_q <= retry_d;
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    i2c_byte = 8'h00;
    unique case (state_q)
      S_SEND_HI: i2c_byte = entry_q[15:8];
      S_SEND_LO: i2c_byte = entry_q[7:0];
      default:   i2c_byte = 8'h00;
    endcase
  end

  assign i2c_enable = (state_q == S_SEND_HI) |
                      (state_q == S_SEND_LO);
  assign i2c_mode   = 1'b1;
  assign i2c_addr   = PERIPH_ADDR;
  assign tbl_idx    = idx_q;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign busy       = ~((state_q == S_IDLE) | done | err);
  assign state_info = state_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// tb_codec_init_seq: directed + random runs of codec_init_seq against a
// behavioural I2C controller and an expected byte-stream model.
module tb_codec_init_seq;

  localparam int         NR = 2;
  localparam int         IW = 4;
  localparam int         PC = 4;
  localparam logic [6:0] PA = 7'b0011010;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] tbl_idx;
  logic [15:0]   tbl_data;
  logic          i2c_enable;
  logic          i2c_mode;
  logic [6:0]    i2c_addr;
  logic [7:0]    i2c_byte;
  logic          i2c_ready = 1'b1;
  logic          i2c_wip = 1'b0;
  logic          i2c_ack_err = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    state_info;

  always #5 clk = ~clk;

  codec_init_seq #(
    .NUM_REGS(NR), .IDX_W(IW),
    .PERIPH_ADDR(PA), .PAUSE_CYCLES(PC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .i2c_enable(i2c_enable), .i2c_mode(i2c_mode),
    .i2c_addr(i2c_addr), .i2c_byte(i2c_byte),
    .i2c_ready(i2c_ready), .i2c_wip(i2c_wip),
    .i2c_ack_err(i2c_ack_err),
    .busy(busy), .done(done), .err(err),
    .state_info(state_info)
  );

  logic [15:0] tbl [16];
  assign tbl_data = tbl[tbl_idx];

  int  phase, cnt, nack_used, cyc, t_rdy, gap, max_idx;
  bit  coin_done, armed, saw_lo;
  int  nack_budget, nack_idx;
  bit  coin_en;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int  ncmp, nfail;

  // behavioural controller: samples at negedge, drives at negedge
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      phase = 0;
      i2c_wip = 1'b0;
      i2c_ready = 1'b1;
      i2c_ack_err = 1'b0;
    end else begin
      if (start) begin
        cap.delete();
        nack_used = 0; coin_done = 0;
        armed = 0; saw_lo = 0;
        max_idx = 0; gap = -1;
      end
      case (phase)
        0: if (i2c_enable) begin
          cap.push_back(i2c_byte);
          i2c_ready = 1'b0;
          if (int'(tbl_idx) == nack_idx &&
              nack_used < nack_budget) begin
            nack_used++;
            i2c_ack_err = 1'b1;
            phase = 3;
          end else begin
            i2c_wip = 1'b1;
            cnt = $urandom_range(1, 3);
            phase = 1;
            if (coin_en && !coin_done && tbl_idx == 0) begin
              coin_done = 1;
              i2c_ack_err = 1'b1;
            end
          end
        end
        1: begin
          i2c_ack_err = 1'b0;
          cnt--;
          if (cnt == 0) begin
            i2c_wip = 1'b0;
            phase = 2;
          end
        end
        2: if (i2c_enable) begin
          cap.push_back(i2c_byte);
          i2c_wip = 1'b1;
          cnt = $urandom_range(1, 3);
          phase = 1;
        end else begin
          i2c_ready = 1'b1;
          phase = 0;
        end
        default: begin
          i2c_ack_err = 1'b0;
          i2c_ready = 1'b1;
          phase = 0;
        end
      endcase
      if (state_info == 4'd3) saw_lo = 1;
      if (int'(tbl_idx) > max_idx) max_idx = int'(tbl_idx);
      if (state_info == 4'd4 && i2c_ready && !armed) begin
        armed = 1;
        t_rdy = cyc;
      end
      if (state_info == 4'd2 && armed) begin
        gap = cyc - t_rdy;
        armed = 0;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap.size()) return {24'h0, cap[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // expected byte stream from the table and the injected faults
  task automatic build_exp(input int nacks, input int nidx,
                           input bit coin);
    int fails;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      fails = (i == nidx) ? nacks : 0;
      if (coin && i == 0) fails++;
`ifdef CODEC_INIT_RETRY_EN
      if (fails > 3) begin
        repeat (4) exp_q.push_back(tbl[i][15:8]);
        return;
      end
      repeat (fails) exp_q.push_back(tbl[i][15:8]);
`else
      if (fails > 0) begin
        exp_q.push_back(tbl[i][15:8]);
        return;
      end
`endif
      exp_q.push_back(tbl[i][15:8]);
      exp_q.push_back(tbl[i][7:0]);
    end
  endtask

  task automatic pulse_start;
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s,
                            input int idx);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (state_info == s && int'(tbl_idx) == idx) break;
    end
    check("wait_state_timeout", 32'(i < 3000), 1);
  endtask

  task automatic finish_seq(input bit expect_err);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done || err) break;
    end
    check("run_timeout", 32'(i < 3000), 1);
    check("stream_len", cap.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("byte%0d", k), cap_at(k),
            {24'h0, exp_q[k]});
    check("done", done, !expect_err);
    check("err", err, expect_err);
    check("busy_end", busy, 0);
    check("enable_end", i2c_enable, 0);
    check("byte_end", i2c_byte, 0);
    check("idx_bound", 32'(max_idx <= NR - 1), 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    nack_budget = 0; nack_idx = 0; coin_en = 0;
    foreach (tbl[i]) tbl[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_info, 0);
    check("rst_enable", i2c_enable, 0);
    check("rst_byte", i2c_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_idx", tbl_idx, 0);
    check("mode", i2c_mode, 1);
    check("addr", i2c_addr, {25'h0, PA});
    @(posedge clk); #2;
    reset = 1'b0;

    // two-entry reference table
    tbl[0] = 16'h1E00;
    tbl[1] = 16'h0E80;
    build_exp(0, 0, 0);
    pulse_start;
    check("busy_run", busy, 1);
    finish_seq(0);
    check("ref_b0", cap_at(0), 32'h1E);
    check("ref_b1", cap_at(1), 32'h00);
    check("ref_b2", cap_at(2), 32'h0E);
    check("ref_b3", cap_at(3), 32'h80);
    check("pause_gap", gap, PC + 3);

    // value 0x1FF at register 0x04
    tbl[0] = 16'h09FF;
    tbl[1] = 16'($urandom);
    build_exp(0, 0, 0);
    pulse_start;
    finish_seq(0);
    check("b9_hi", cap_at(0), 32'h09);
    check("b9_lo", cap_at(1), 32'hFF);

    repeat (4) begin
      tbl[0] = 16'($urandom);
      tbl[1] = 16'($urandom);
      build_exp(0, 0, 0);
      pulse_start;
      finish_seq(0);
      check("rand_gap", gap, PC + 3);
    end

    // start during SEND_LO is ignored
    tbl[0] = 16'($urandom);
    tbl[1] = 16'($urandom);
    build_exp(0, 0, 0);
    pulse_start;
    wait_state(4'd3, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_not_load", 32'(state_info == 4'd1), 0);
    check("ign_idx", tbl_idx, 1);
    finish_seq(0);

    // start in DONE reruns from entry 0
    pulse_start;
    check("rerun_state", state_info, 1);
    check("rerun_idx", tbl_idx, 0);
    finish_seq(0);

    // asynchronous reset in SEND_LO
    pulse_start;
    wait_state(4'd3, 0);
    #1 reset = 1'b1;
    #1;
    check("arst_state", state_info, 0);
    check("arst_enable", i2c_enable, 0);
    check("arst_byte", i2c_byte, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1;
    check("arst_idx", tbl_idx, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // entry 1 NACKed twice
    tbl[0] = 16'($urandom);
    tbl[1] = 16'($urandom);
    nack_idx = 1;
    nack_budget = 2;
    build_exp(2, 1, 0);
    pulse_start;
`ifdef CODEC_INIT_RETRY_EN
    finish_seq(0);
`else
    finish_seq(1);
    check("nack_idx", tbl_idx, 1);
`endif
    nack_budget = 0;

    // NACK coincident with wip rise on entry 0
    coin_en = 1;
    build_exp(0, 0, 1);
    pulse_start;
`ifdef CODEC_INIT_RETRY_EN
    finish_seq(0);
`else
    finish_seq(1);
    check("coin_no_lo", saw_lo, 0);
    check("coin_idx", tbl_idx, 0);
`endif
    coin_en = 0;

    // recovery run after the fault cases
    tbl[0] = 16'($urandom);
    tbl[1] = 16'($urandom);
    build_exp(0, 0, 0);
    pulse_start;
    finish_seq(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
